layer_priority_arbiter: RTL and testbench
=========================================

// Module: layer_priority_arbiter
// PURPOSE
//  Pipelined per-pixel arbiter that shares the single VGA RGB output among N sprite/tile layers.
//  Layer priority is programmable at run time; writes are double-buffered and committed only at frame start.
//  Sits between the sprite/wall pixel generators and the VGA DAC pins.
//  Also delays h_cnt/v_cnt and valid so they stay aligned with the arbitrated pixel.
// PARAMETERS
//  N_LAYERS   8        number of requester layers (2..8)
//  BG_COLOR   12'hFDA  playfield background colour
//  HUD_COLOR  12'h000  HUD band colour
//  HUD_LINES  20       rows v_cnt < HUD_LINES use HUD_COLOR when no layer is opaque
//  FADE_DIV   4        frames per fade step (FADE_EN only)
// PORTS
//  clk         in   1          pixel clock
//  rst         in   1          synchronous, active-high reset
//  valid_in    in   1          active-video flag for the current pixel
//  h_cnt       in   10         current column
//  v_cnt       in   10         current row
//  frame_start in   1          one-cycle pulse at first pixel of a frame
//  layer_pix   in   12*N       layer i occupies bits [12i+11:12i]; 12'h000 = transparent
//  prio_wr     in   1          write strobe for the priority shadow table
//  prio_idx    in   3          layer index written
//  prio_val    in   3          rank written (0 = highest priority)
//  fade_start  in   1          start fade-to-black (FADE_EN only, ignored otherwise)
//  rgb_out     out  12         arbitrated colour
//  valid_out   out  1          valid_in delayed by 2 cycles
//  h_cnt_out   out  10         h_cnt delayed by 2 cycles
//  v_cnt_out   out  10         v_cnt delayed by 2 cycles
//  hit_layer   out  3          index of the winning layer (0 when none)
//  hit_valid   out  1          1 when some layer was opaque at this pixel
//  fade_done   out  1          level reached 0 (held 0 without FADE_EN)
// BEHAVIOUR
//  Reset: all outputs 0; both shadow and active rank tables reset to rank[i] = i; fade FSM goes to IDLE, level 16.
//  Latency: fixed 2 cycles from inputs to rgb_out/valid_out/hit_*/counters; throughput 1 pixel/cycle, no stalls.
//  Stage 1 registers:
//   - opaque mask: op[i] = |layer_pix[i];
//   - all pixels, valid_in, h_cnt, v_cnt, HUD flag (v_cnt < HUD_LINES).
//  Stage 2 selects, among opaque layers, the one with the minimum active rank.
//   - Ties go to the lowest layer index; duplicate ranks are legal.
//  Output rules, in order:
//   - valid=0: rgb_out = 0, hit_valid = 0.
//   - No opaque layer: rgb_out = HUD_COLOR if the HUD flag is set, else BG_COLOR; hit_valid = 0.
//   - Otherwise: rgb_out = the winning layer's pixel, hit_layer = its index, hit_valid = 1.
//   - Colours are never summed or blended.
//  Priority writes:
//   - prio_wr writes shadow[prio_idx] = prio_val.
//   - prio_idx >= N_LAYERS is ignored.
//   - On frame_start the active table loads the shadow table as it was before that cycle.
//   - A write coinciding with frame_start updates the shadow but is committed at the next frame_start.
//   - The active table never changes mid-frame.
//  rst asserted mid-frame: pipeline is flushed (outputs 0 next cycle) and both tables return to the reset value.
// CONFIGURATION
//  FADE_EN defined:
//   - FSM IDLE -> FADING on fade_start.
//   - FADING: level decrements by 1 every FADE_DIV frame_start pulses.
//   - FADING -> BLACK when level reaches 0; fade_done = 1 in BLACK.
//   - BLACK holds until rst.
//   - fade_start outside IDLE is ignored.
//   - Stage 2 scales every colour, including BG/HUD: each 4-bit channel c becomes (c*level)>>4; level 16 passes c unchanged.
//   - Level changes only on frame_start.
//  FADE_EN undefined:
//   - No FSM; level is fixed at 16; fade_start is ignored; fade_done is tied 0.
//   - Latency is still 2.
// TESTING
//  1 Reset defaults:
//    - Set valid_in=1, v_cnt=100, layer 2=12'h0F0, layer 5=12'h00F.
//    - Expect rgb_out 12'h0F0 and hit_layer 2, two cycles later.
//  2 Background and HUD:
//    - With all layers 0, drive v_cnt=5 then v_cnt=200.
//    - Expect rgb_out 12'h000, then 12'hFDA; hit_valid 0.
//  3 Frame-aligned reprogram:
//    - Write rank[5]=0 and rank[2]=1 mid-frame; the output stays 12'h0F0.
//    - After frame_start, the same inputs give 12'h00F.
//  4 Write coinciding with frame_start: the write is not visible until the second frame_start.
//  5 Tie and valid:
//    - Give layers 1 and 3 both rank 0 with pixels 12'h111 and 12'h333; expect 12'h111.
//    - Drop valid_in; expect rgb_out 0 two cycles later.
//  6 FADE_EN:
//    - Set FADE_DIV=1, pulse fade_start, then apply 8 frame_start pulses.
//    - BG 12'hFDA must become 12'h765 ((c*8)>>4 per channel).
//    - After 16 pulses rgb_out is 0 and fade_done is 1.

Source files
------------

// File: rtl/layer_priority_arbiter.sv
// layer_priority_arbiter
//   Two-stage per-pixel arbiter that picks one of N_LAYERS layer colours for
//   the single VGA RGB output. The layer with the lowest programmable rank
//   wins. On a rank tie, the lowest layer index wins. Rank writes land in a
//   shadow table. The shadow table is copied to the active table only on
//   frame_start, so the arbitration never changes mid-frame.
//   Optional build macro FADE_EN adds a frame-paced fade-to-black FSM. This
//   FSM scales every output colour, background and HUD included.
// Ports
//   clk, rst           pixel clock, synchronous active-high reset
//   valid_in           active-video flag
//   h_cnt, v_cnt       pixel coordinates
//   frame_start        one-cycle pulse at the first pixel of a frame
//   layer_pix          12 bits per layer, layer i at [12i+11:12i], 0 = transparent
//   prio_wr            write strobe for the shadow rank table
//   prio_idx, prio_val layer index and rank value written (rank 0 = highest priority)
//   fade_start         begins the fade (only with FADE_EN)
//   rgb_out            arbitrated colour, 2 cycles after the inputs
//   valid_out          valid_in delayed to match rgb_out
//   h_cnt_out, v_cnt_out coordinates delayed to match rgb_out
//   hit_layer          index of the winning layer
//   hit_valid          1 when some layer was opaque at this pixel
//   fade_done          fade has reached black (0 without FADE_EN)
module layer_priority_arbiter #(
    parameter int          N_LAYERS  = 8,
    parameter logic [11:0] BG_COLOR  = 12'hFDA,
    parameter logic [11:0] HUD_COLOR = 12'h000,
    parameter int          HUD_LINES = 20,
    parameter int          FADE_DIV  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    frame_start,
    input  logic [12*N_LAYERS-1:0]  layer_pix,
    input  logic                    prio_wr,
    input  logic [2:0]              prio_idx,
    input  logic [2:0]              prio_val,
    input  logic                    fade_start,
    output logic [11:0]             rgb_out,
    output logic                    valid_out,
    output logic [9:0]              h_cnt_out,
    output logic [9:0]              v_cnt_out,
    output logic [2:0]              hit_layer,
    output logic                    hit_valid,
    output logic                    fade_done
);
    localparam int STAGES = 2;

    logic [N_LAYERS-1:0][2:0]  shadow_rank, active_rank;
    logic [N_LAYERS-1:0][11:0] pix_s1;
    logic [N_LAYERS-1:0]       op_s1;
    logic                      hud_s1;
    logic [9:0]                h_s1, v_s1;
    logic [STAGES:1]           vld_pipe;
    logic [4:0]                level;

    // Rank tables. An index that matches no layer is simply dropped.
    // frame_start copies the shadow table as it was before this edge, so a
    // write in the same cycle is committed at the following frame_start.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LAYERS; i++) begin
            if (rst) begin
                shadow_rank[i] <= 3'(i);
                active_rank[i] <= 3'(i);
            end else begin
                if (prio_wr && prio_idx == 3'(i)) shadow_rank[i] <= prio_val;
                if (frame_start)                  active_rank[i] <= shadow_rank[i];
            end
        end
    end

    // Stage 1: capture pixels, opacity mask and coordinates.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_s1   <= '0;
            op_s1    <= '0;
            hud_s1   <= 1'b0;
            h_s1     <= '0;
            v_s1     <= '0;
            vld_pipe <= '0;
        end else begin
            for (int i = 0; i < N_LAYERS; i++) begin
                pix_s1[i] <= layer_pix[12*i +: 12];
                op_s1[i]  <= |layer_pix[12*i +: 12];
            end
            hud_s1   <= (v_cnt < 10'(HUD_LINES));
            h_s1     <= h_cnt;
            v_s1     <= v_cnt;
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
        end
    end

    // Stage 2 select. The strict '<' keeps the earliest index on a rank tie.
    logic        found;
    logic [2:0]  win_idx, win_rank;
    logic [11:0] win_pix, base_rgb, scaled_rgb;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_rank = '1;
        win_pix  = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (op_s1[i] && (!found || active_rank[i] < win_rank)) begin
                found    = 1'b1;
                win_idx  = 3'(i);
                win_rank = active_rank[i];
                win_pix  = pix_s1[i];
            end
        end
        base_rgb = found ? win_pix : (hud_s1 ? HUD_COLOR : BG_COLOR);
    end

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
        logic [8:0] p;
        p = {5'b0, c} * {4'b0, lvl};
        return p[7:4];
    endfunction

    assign scaled_rgb = {scale(base_rgb[11:8], level),
                         scale(base_rgb[7:4],  level),
                         scale(base_rgb[3:0],  level)};

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out   <= '0;
            hit_layer <= '0;
            hit_valid <= 1'b0;
            h_cnt_out <= '0;
            v_cnt_out <= '0;
        end else begin
            rgb_out   <= vld_pipe[1] ? scaled_rgb : 12'h000;
            hit_layer <= (vld_pipe[1] && found) ? win_idx : 3'd0;
            hit_valid <= vld_pipe[1] && found;
            h_cnt_out <= h_s1;
            v_cnt_out <= v_s1;
        end
    end

    assign valid_out = vld_pipe[STAGES];

`ifdef FADE_EN
    typedef enum logic [1:0] {IDLE, FADING, BLACK} fade_state_t;
    fade_state_t state, state_nx;
    logic [4:0]  level_nx;
    logic [7:0]  div_cnt, div_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            level   <= 5'd16;
            div_cnt <= '0;
        end else begin
            state   <= state_nx;
            level   <= level_nx;
            div_cnt <= div_nx;
        end
    end

    // The level steps only on frame_start, once every FADE_DIV pulses.
    always_comb begin
        state_nx = state;
        level_nx = level;
        div_nx   = div_cnt;
        case (state)
            IDLE:   if (fade_start) begin
                        state_nx = FADING;
                        div_nx   = '0;
                    end
            FADING: if (frame_start) begin
                        if (div_cnt == 8'(FADE_DIV - 1)) begin
                            div_nx   = '0;
                            level_nx = level - 5'd1;
                            if (level == 5'd1) state_nx = BLACK;
                        end else begin
                            div_nx = div_cnt + 8'd1;
                        end
                    end
            default: ;
        endcase
    end

    assign fade_done = (state == BLACK);
`else
    logic unused_fade;
    assign unused_fade = fade_start ^ (FADE_DIV == 0);
    assign level       = 5'd16;
    assign fade_done   = 1'b0;
`endif
endmodule

// File: tb/tb_layer_priority_arbiter.sv
module tb_layer_priority_arbiter;
    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst, valid_in, frame_start, prio_wr, fade_start;
    logic [9:0]      h_cnt, v_cnt;
    logic [12*N-1:0] layer_pix;
    logic [2:0]      prio_idx, prio_val;
    logic [11:0]     rgb_out;
    logic            valid_out, hit_valid, fade_done;
    logic [9:0]      h_cnt_out, v_cnt_out;
    logic [2:0]      hit_layer;
    int              tests = 0, fails = 0;

    always #5 clk = ~clk;

    layer_priority_arbiter #(.N_LAYERS(N), .FADE_DIV(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .layer_pix(layer_pix), .prio_wr(prio_wr),
        .prio_idx(prio_idx), .prio_val(prio_val), .fade_start(fade_start),
        .rgb_out(rgb_out), .valid_out(valid_out), .h_cnt_out(h_cnt_out),
        .v_cnt_out(v_cnt_out), .hit_layer(hit_layer), .hit_valid(hit_valid),
        .fade_done(fade_done));

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pix(input int i, input logic [11:0] c);
        layer_pix[12*i +: 12] = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_rank(input logic [2:0] idx, input logic [2:0] val);
        prio_wr = 1'b1; prio_idx = idx; prio_val = val;
        step();
        prio_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; frame_start = 1'b0; prio_wr = 1'b0;
        fade_start = 1'b0; h_cnt = '0; v_cnt = '0; layer_pix = '0;
        prio_idx = '0; prio_val = '0;
        step(2);
        chk("reset_rgb", rgb_out, 12'h000);
        chk("reset_valid", valid_out, 0);
        chk("reset_hit_valid", hit_valid, 0);
        chk("reset_fade_done", fade_done, 0);
        rst = 1'b0;

        // Default ranks: layer 2 beats layer 5
        valid_in = 1'b1; h_cnt = 10'd37; v_cnt = 10'd100;
        set_pix(2, 12'h0F0); set_pix(5, 12'h00F);
        step(2);
        chk("dflt_rgb", rgb_out, 12'h0F0);
        chk("dflt_hit_layer", hit_layer, 2);
        chk("dflt_hit_valid", hit_valid, 1);
        chk("dflt_valid_out", valid_out, 1);
        chk("dflt_h_out", h_cnt_out, 37);
        chk("dflt_v_out", v_cnt_out, 100);

        // Background / HUD, including the HUD_LINES boundary
        layer_pix = '0;
        v_cnt = 10'd5;   step(2);
        chk("hud_rgb", rgb_out, 12'h000);
        chk("hud_hit_valid", hit_valid, 0);
        chk("hud_hit_layer", hit_layer, 0);
        v_cnt = 10'd19;  step(2);
        chk("hud_edge19_rgb", rgb_out, 12'h000);
        v_cnt = 10'd20;  step(2);
        chk("bg_edge20_rgb", rgb_out, 12'hFDA);
        v_cnt = 10'd200; step(2);
        chk("bg_rgb", rgb_out, 12'hFDA);
        chk("bg_hit_valid", hit_valid, 0);

        // Mid-frame rank writes are held until frame_start
        v_cnt = 10'd100;
        set_pix(2, 12'h0F0); set_pix(5, 12'h00F);
        wr_rank(3'd5, 3'd0);
        wr_rank(3'd2, 3'd1);
        step(2);
        chk("midframe_rgb", rgb_out, 12'h0F0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step(2);
        chk("commit_rgb", rgb_out, 12'h00F);
        chk("commit_hit_layer", hit_layer, 5);

        // A write in the frame_start cycle waits for the next frame_start
        frame_start = 1'b1; prio_wr = 1'b1; prio_idx = 3'd2; prio_val = 3'd0;
        step();
        frame_start = 1'b0; prio_wr = 1'b0;
        step(2);
        chk("coinc_first_rgb", rgb_out, 12'h00F);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        step(2);
        chk("coinc_second_rgb", rgb_out, 12'h0F0);
        chk("coinc_tie_hit_layer", hit_layer, 2);

        // Equal ranks: lower index wins
        wr_rank(3'd1, 3'd0);
        wr_rank(3'd3, 3'd0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        layer_pix = '0; set_pix(1, 12'h111); set_pix(3, 12'h333);
        step(2);
        chk("tie_rgb", rgb_out, 12'h111);
        chk("tie_hit_layer", hit_layer, 1);
        valid_in = 1'b0; step(2);
        chk("novalid_rgb", rgb_out, 12'h000);
        chk("novalid_hit_valid", hit_valid, 0);
        chk("novalid_valid_out", valid_out, 0);

        // Mid-frame reset flushes outputs and restores the default ranks
        valid_in = 1'b1; rst = 1'b1; step();
        chk("midrst_rgb", rgb_out, 12'h000);
        chk("midrst_valid_out", valid_out, 0);
        rst = 1'b0;
        layer_pix = '0; set_pix(4, 12'h444); set_pix(5, 12'h00F);
        step(2);
        chk("postrst_rgb", rgb_out, 12'h444);
        chk("postrst_hit_layer", hit_layer, 4);

        // Fade: level 8 after 8 pulses halves each channel, black after 16
        layer_pix = '0; v_cnt = 10'd200;
        fade_start = 1'b1; step(); fade_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0; step();
        end
        step(2);
`ifdef FADE_EN
        chk("fade8_rgb", rgb_out, 12'h765);
        chk("fade8_done", fade_done, 0);
        for (int k = 0; k < 8; k++) begin
            frame_start = 1'b1; step(); frame_start = 1'b0; step();
        end
        step(2);
        chk("fade16_rgb", rgb_out, 12'h000);
        chk("fade16_done", fade_done, 1);
`else
        chk("nofade_rgb", rgb_out, 12'hFDA);
        chk("nofade_done", fade_done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
